// File: rtl/combi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : combi_pkg
//  Purpose  : Shared definitions for the combinational-result pipeline:
//             2-bit opcode encodings and the per-result flag bundle that is
//             stored next to each result in the buffer.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package combi_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // Flags kept alongside every result. The result field itself depends on
    // the DATA_W parameter of the instantiating module, so the full entry
    // struct {result, ovf, dz} is completed there with this bundle as its tail.
    typedef struct packed {
        logic ovf;
        logic dz;
    } result_flags_t;

    localparam int unsigned FLAGS_W = $bits(result_flags_t);

endpackage : combi_pkg
`default_nettype wire

// File: rtl/combi_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : combi_result_fifo
//  Purpose  : Synchronous FIFO holding finished result entries.
//  Ports    : clk, reset_n (async active-low)
//             i_push / i_wdata  - write request and entry
//             i_pop             - read request (head advances)
//             o_rdata           - head entry (zero while empty)
//             o_full / o_empty  - occupancy boundaries
//             o_count           - occupancy, 0..DEPTH
//  Revision : 1.0 - initial release
// ============================================================================
module combi_result_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic w_push;
    logic w_pop;

    assign o_full  = (count_q == CNT_W'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;

    // Requests are qualified here as well, so the FIFO can never over- or
    // underflow even if a caller ignores full/empty.
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop  && !o_empty;

    // Head is forced to zero while empty so nothing stale or uninitialised
    // ever reaches the outputs.
    assign o_rdata = o_empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so natural pointer overflow is the wrap.
        if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= i_wdata;
        end
    end

endmodule : combi_result_fifo
`default_nettype wire

// File: rtl/combi_result_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : combi_result_pipe
//  Purpose  : Registered, flow-controlled stage for the add/sub/mul/div
//             datapath. Each accepted beat is computed in the push cycle,
//             tagged with overflow / divide-by-zero flags and buffered in a
//             small FIFO that feeds a valid/ready consumer.
//  Ports    : clk, reset_n (async active-low)
//             upstream  : i_valid, o_ready, i_op, i_value_a, i_value_b
//             downstream: o_valid, i_ready, o_result, o_flag_ovf, o_flag_dz
//             status    : o_count (FIFO occupancy)
//  Config   : COMBI_RESULT_SAT_EN - when defined, add/mul overflow saturate
//             to all-ones and sub borrow saturates to zero (flags still set).
//  Revision : 1.0 - initial release
// ============================================================================
module combi_result_pipe
    import combi_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [1:0]                    i_op,
    input  logic [DATA_W-1:0]             i_value_a,
    input  logic [DATA_W-1:0]             i_value_b,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [DATA_W-1:0]             o_result,
    output logic                          o_flag_ovf,
    output logic                          o_flag_dz,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);

    typedef struct packed {
        logic [DATA_W-1:0] result;
        result_flags_t     flags;
    } entry_t;

    localparam int unsigned ENTRY_W = $bits(entry_t);

    logic [DATA_W:0]     w_sum;
    logic [DATA_W:0]     w_diff;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_quot;
    entry_t              w_entry;
    entry_t              w_head;
    logic [ENTRY_W-1:0]  w_head_raw;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;

    // Zero-extended operands keep the carry/borrow in the top bit.
    assign w_sum  = {1'b0, i_value_a} + {1'b0, i_value_b};
    assign w_diff = {1'b0, i_value_a} - {1'b0, i_value_b};
    assign w_prod = {{DATA_W{1'b0}}, i_value_a} * {{DATA_W{1'b0}}, i_value_b};
    assign w_quot = (i_value_b == '0) ? '1 : (i_value_a / i_value_b);

    always_comb begin
        w_entry           = '0;
        case (i_op)
            OP_ADD: begin
                w_entry.result    = w_sum[DATA_W-1:0];
                w_entry.flags.ovf = w_sum[DATA_W];
            end
            OP_SUB: begin
                w_entry.result    = w_diff[DATA_W-1:0];
                w_entry.flags.ovf = w_diff[DATA_W];
            end
            OP_MUL: begin
                w_entry.result    = w_prod[DATA_W-1:0];
                w_entry.flags.ovf = |w_prod[2*DATA_W-1:DATA_W];
            end
            default: begin
                w_entry.result    = w_quot;
                w_entry.flags.dz  = (i_value_b == '0);
            end
        endcase
`ifdef COMBI_RESULT_SAT_EN
        // Clamp toward the side the true result fell off; div never sets ovf.
        if (w_entry.flags.ovf) begin
            w_entry.result = (i_op == OP_SUB) ? '0 : '1;
        end
`endif
    end

    // Ready comes only from registered occupancy, never from i_ready, so a
    // pop at full cannot let a push through in the same cycle.
    assign o_ready = !w_full;
    assign o_valid = !w_empty;
    assign w_push  = i_valid && o_ready;
    assign w_pop   = o_valid && i_ready;

    combi_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_wdata (w_entry),
        .i_pop   (w_pop),
        .o_rdata (w_head_raw),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (o_count)
    );

    assign w_head     = entry_t'(w_head_raw);
    assign o_result   = w_head.result;
    assign o_flag_ovf = w_head.flags.ovf;
    assign o_flag_dz  = w_head.flags.dz;

endmodule : combi_result_pipe
`default_nettype wire

// File: tb/tb_combi_result_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_combi_result_pipe
//  Purpose  : Self-checking bench for combi_result_pipe. Expected entries are
//             queued from an arithmetic model at accept time and compared as
//             the DUT hands results downstream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_combi_result_pipe;
    import combi_pkg::*;

    localparam int W = 8;
    localparam int D = 4;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 i_valid;
    logic                 o_ready;
    logic [1:0]           i_op;
    logic [W-1:0]         i_value_a;
    logic [W-1:0]         i_value_b;
    logic                 o_valid;
    logic                 i_ready;
    logic [W-1:0]         o_result;
    logic                 o_flag_ovf;
    logic                 o_flag_dz;
    logic [$clog2(D):0]   o_count;

    int n_total = 0;
    int n_bad   = 0;

    // Entry layout: {ovf, dz, result}
    logic [W+1:0] sb_q [$];
    logic [W+1:0] exp_e;

    combi_result_pipe #(
        .DATA_W     (W),
        .FIFO_DEPTH (D)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_op       (i_op),
        .i_value_a  (i_value_a),
        .i_value_b  (i_value_b),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_result   (o_result),
        .o_flag_ovf (o_flag_ovf),
        .o_flag_dz  (o_flag_dz),
        .o_count    (o_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [W+1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        int unsigned ia, ib, r, maxv;
        logic ovf, dz;
        ia   = a;
        ib   = b;
        maxv = (1 << W) - 1;
        ovf  = 1'b0;
        dz   = 1'b0;
        case (op)
            2'd0: begin
                r   = ia + ib;
                ovf = (r > maxv);
                r   = r & maxv;
`ifdef COMBI_RESULT_SAT_EN
                if (ovf) r = maxv;
`endif
            end
            2'd1: begin
                ovf = (ia < ib);
                r   = (ia - ib) & maxv;
`ifdef COMBI_RESULT_SAT_EN
                if (ovf) r = 0;
`endif
            end
            2'd2: begin
                r   = ia * ib;
                ovf = (r > maxv);
                r   = r & maxv;
`ifdef COMBI_RESULT_SAT_EN
                if (ovf) r = maxv;
`endif
            end
            default: begin
                if (ib == 0) begin
                    r  = maxv;
                    dz = 1'b1;
                end else begin
                    r = ia / ib;
                end
            end
        endcase
        return {ovf, dz, r[W-1:0]};
    endfunction

    // Scoreboard: decisions taken on the falling edge, where the values the
    // next rising edge will act on are already stable.
    always @(negedge clk) begin
        if (reset_n) begin
            if (o_valid && i_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out", 32'd1, 32'd0);
                end else begin
                    exp_e = sb_q.pop_front();
                    check("result", o_result,   exp_e[W-1:0]);
                    check("ovf",    o_flag_ovf, exp_e[W+1]);
                    check("dz",     o_flag_dz,  exp_e[W]);
                end
            end
            if (i_valid && o_ready) begin
                sb_q.push_back(model(i_op, i_value_a, i_value_b));
            end
        end
    end

    task automatic drive(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        i_valid   = 1'b1;
        i_op      = op;
        i_value_a = a;
        i_value_b = b;
    endtask

    // Returns #1 after the rising edge that accepted the driven beat.
    task automatic wait_accept();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (o_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        drive(op, a, b);
        wait_accept();
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        i_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !o_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("drain_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        i_valid   = 1'b0;
        i_ready   = 1'b1;
        i_op      = 2'd0;
        i_value_a = '0;
        i_value_b = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", o_valid,    32'd0);
        check("rst_count", o_count,    32'd0);
        check("rst_result", o_result,  32'd0);
        check("rst_ovf",   o_flag_ovf, 32'd0);
        check("rst_dz",    o_flag_dz,  32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_ready", o_ready, 32'd1);
        @(posedge clk);
        #1;

        // 1: all four ops back-to-back, each result one cycle after accept
        for (int k = 0; k <= 4; k++) begin
            if (k < 4) drive(2'(k), 8'd20, 8'd10);
            else       i_valid = 1'b0;
            @(negedge clk);
            if (k > 0) begin
                check("lat_valid", o_valid, 32'd1);
                check("lat_count", o_count, 32'd1);
            end
            @(posedge clk);
            #1;
        end
        drain();

        // 2/3: overflow, borrow, divide-by-zero and edge operands
        send(OP_ADD, 8'd200, 8'd100);
        send(OP_SUB, 8'd10,  8'd20);
        send(OP_MUL, 8'd20,  8'd20);
        send(OP_DIV, 8'd20,  8'd0);
        send(OP_DIV, 8'd255, 8'd1);
        send(OP_MUL, 8'd15,  8'd17);
        send(OP_ADD, 8'd255, 8'd0);
        send(OP_SUB, 8'd0,   8'd0);
        send(OP_ADD, 8'd255, 8'd1);
        drain();

        // 4: fill to full with consumer stalled, 5th beat held off
        i_ready = 1'b0;
        send(OP_ADD, 8'd1, 8'd2);
        send(OP_SUB, 8'd9, 8'd4);
        send(OP_MUL, 8'd3, 8'd5);
        send(OP_DIV, 8'd90, 8'd9);
        drive(OP_ADD, 8'd7, 8'd9);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_ready", o_ready, 32'd0);
            check("full_count", o_count, D);
            check("hold_result", o_result, sb_q[0][W-1:0]);
        end
        @(posedge clk);
        #1;
        i_ready = 1'b1;
        wait_accept();
        drain();

        // 5: steady push+pop at occupancy 2
        i_ready = 1'b0;
        send(OP_ADD, 8'd11, 8'd22);
        send(OP_SUB, 8'd33, 8'd3);
        i_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(2'($urandom_range(3)), 8'($urandom_range(255)), 8'($urandom_range(255)));
            check("steady_count", o_count, 32'd2);
        end
        drain();

        // 6: reset with three results buffered
        i_ready = 1'b0;
        send(OP_ADD, 8'd1, 8'd1);
        send(OP_ADD, 8'd2, 8'd2);
        send(OP_ADD, 8'd3, 8'd3);
        i_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_count", o_count, 32'd3);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", o_valid, 32'd0);
        check("mid_rst_count", o_count, 32'd0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", o_ready, 32'd1);
        check("post_rst_valid", o_valid, 32'd0);
        @(posedge clk);
        #1;
        i_ready = 1'b1;
        send(OP_SUB, 8'd50, 8'd8);
        i_valid = 1'b0;
        @(negedge clk);
        check("post_rst_first_v", o_valid, 32'd1);
        check("post_rst_first", o_result, 32'd42);
        @(posedge clk);
        #1;
        drain();
        check("sb_empty", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_combi_result_pipe
`default_nettype wire
